// File: rtl/top_pkg.sv
// Shared defaults for the counter demo and the bit layout of the led bus.
// No handshakes: all values are static constants.
package top_pkg;
  localparam int DEF_MOD_N  = 6;
  localparam int DEF_RING_W = 4;

  localparam int LED_MC_OUT = 6;
  localparam int LED_MC_MSB = 5;
  localparam int LED_MC_LSB = 3;
  localparam int LED_RC_MSB = 2;
  localparam int LED_RC_LSB = 0;
endpackage

// File: rtl/mod_counter.sv
// Modulo-MOD_N counter with a toggle flag that flips on each wrap; outputs are registered.
// Free-running every clock with no stall input; unreachable counts recover to 0 without toggling.
module mod_counter #(
  parameter int MOD_N = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [2:0] count,
  output logic       tog
);
  localparam logic [2:0] LAST = 3'(MOD_N - 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= 3'd0;
      tog   <= 1'b0;
    end else if (count == LAST) begin
      count <= 3'd0;
      tog   <= ~tog;
    end else if (count > LAST) begin
      count <= 3'd0;
    end else begin
      count <= count + 3'd1;
    end
  end
endmodule

// File: rtl/top.sv
// Modulo counter plus Johnson ring counter, both free-running on btnC and shown on led from flops.
// No flow control; btnU low clears everything asynchronously.
module top
  import top_pkg::*;
#(
  parameter int MOD_N  = DEF_MOD_N,
  parameter int RING_W = DEF_RING_W
) (
  input  logic       btnC,
  input  logic       btnU,
  output logic [6:0] led
);
  logic [2:0]        mc_state;
  logic              mc_out;
  logic [RING_W-1:0] ring;
  logic [RING_W-1:0] therm;
  logic              ring_ok;

  mod_counter #(.MOD_N(MOD_N)) u_mc (
    .clk   (btnC),
    .rst_n (btnU),
    .count (mc_state),
    .tog   (mc_out)
  );

  // Legal Johnson states are low-side or high-side thermometer codes.
  always_comb begin
    ring_ok = 1'b0;
    therm   = '0;
    for (int k = 0; k <= RING_W; k++) begin
      therm = ~({RING_W{1'b1}} << k);
      if (ring == therm || ring == ~therm) ring_ok = 1'b1;
    end
  end

  always_ff @(posedge btnC or negedge btnU) begin
    if (!btnU) begin
      ring <= '0;
    end else if (ring_ok) begin
      ring <= {ring[RING_W-2:0], ~ring[RING_W-1]};
    end else begin
      ring <= '0;
    end
  end

  assign led[LED_MC_OUT]             = mc_out;
  assign led[LED_MC_MSB:LED_MC_LSB]  = mc_state;
  assign led[LED_RC_MSB:LED_RC_LSB]  = ring[2:0];
endmodule

// File: tb/tb_top.sv
// Directed bench for top: reset behaviour, the first sixteen edges, async mid-count reset, and a 48-edge run.
module tb_top;
  logic       btnC;
  logic       btnU;
  logic [6:0] led;

  int checks = 0;
  int errors = 0;

  top dut (
    .btnC (btnC),
    .btnU (btnU),
    .led  (led)
  );

  initial btnC = 1'b0;
  always #5 btnC = ~btnC;

  // Expected led {mc_out, mc_state, ring[2:0]} after edge n following reset release.
  logic [6:0] exp_tab [1:16] = '{
    7'b0_001_001, 7'b0_010_011, 7'b0_011_111, 7'b0_100_111,
    7'b0_101_110, 7'b1_000_100, 7'b1_001_000, 7'b1_010_000,
    7'b1_011_001, 7'b1_100_011, 7'b1_101_111, 7'b0_000_111,
    7'b0_001_110, 7'b0_010_100, 7'b0_011_000, 7'b0_100_000
  };

  task automatic check_led(input string tag, input logic [6:0] exp);
    checks++;
    assert (led === exp) else begin
      errors++;
      $error("FAIL %s: led=%b expected %b", tag, led, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    int toggles;
    int ring_zeros;
    logic prev_out;
    logic [2:0] prev_rc;

    btnU = 1'b0;
    #1;
    check_led("reset_t0", 7'b0);
    for (int i = 0; i < 4; i++) begin
      @(posedge btnC); #1;
      check_led($sformatf("reset_hold_%0d", i), 7'b0);
    end

    @(negedge btnC);
    btnU = 1'b1;
    for (int e = 1; e <= 16; e++) begin
      @(posedge btnC); #1;
      check_led($sformatf("edge_%0d", e), exp_tab[e]);
    end

    // Mid-count (mc_state=4): reset must clear led before any further edge.
    #2;
    btnU = 1'b0;
    #1;
    check_led("async_reset_mid", 7'b0);
    for (int i = 0; i < 3; i++) begin
      @(posedge btnC); #1;
      check_led($sformatf("reset_hold2_%0d", i), 7'b0);
    end

    @(negedge btnC);
    btnU = 1'b1;
    toggles    = 0;
    ring_zeros = 0;
    prev_out   = led[6];
    prev_rc    = led[2:0];
    for (int e = 1; e <= 48; e++) begin
      @(posedge btnC); #1;
      if (e == 1) check_led("first_edge_after_release", 7'b0_001_001);
      checks++;
      assert (led[5:3] <= 3'd5) else begin
        errors++;
        $error("FAIL mc_range_%0d: mc_state=%0d expected <=5", e, led[5:3]);
      end
      if (led[6] !== prev_out) toggles++;
      // rc=000 twice in a row means the ring went 1000 -> 0000.
      if (led[2:0] == 3'b000 && prev_rc == 3'b000) ring_zeros++;
      prev_out = led[6];
      prev_rc  = led[2:0];
    end
    check_int("mc_out_toggles_48", toggles, 8);
    check_int("ring_zero_returns_48", ring_zeros, 6);
    check_led("edge_48_state", 7'b0_000_000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
